ps2_kbd_mmio: RTL and testbench

//  Receive-only PS/2 keyboard front end that feeds scan codes to the processor through memory-mapped I/O.
//  It synchronises ps2_clk/ps2_data, deframes 11-bit PS/2 frames, and checks parity and the stop bit.

---
 rtl/ps2_kbd_mmio_if.sv | 12 +
 rtl/ps2_kbd_mmio.sv | 195 +++++++++++++++++++
 tb/tb_ps2_kbd_mmio.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/ps2_kbd_mmio_if.sv
// Processor dmem-side bus between the CPU read mux and the PS/2 keyboard block.
// Ports: addr/wren are driven by the processor (master).
//        rdata/hit are returned by the peripheral (slave).
interface ps2_kbd_mmio_if;
  logic [31:0] addr;
  logic        wren;
  logic [31:0] rdata;
  logic        hit;

  modport master (output addr, output wren, input rdata, input hit);
  modport slave  (input addr, input wren, output rdata, output hit);
endinterface

// File: rtl/ps2_kbd_mmio.sv
// Receive-only PS/2 keyboard front end exposing scan codes as memory-mapped I/O.
// Ports: clock/reset (async active-low); ps2_clk/ps2_data raw pins; bus (slave) carries
//        addr/wren in and rdata/hit out; key_avail is high while the scan-code FIFO holds data.
module ps2_kbd_mmio #(
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int ADDR_STATUS    = 4098,
  parameter int ADDR_DATA      = 4099
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            ps2_clk,
  input  logic            ps2_data,
  ps2_kbd_mmio_if.slave   bus,
  output logic            key_avail
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  // ------------------------------------------------------------------
  // Pin synchronisers and falling-edge detect
  // ------------------------------------------------------------------
  logic clk_s1, clk_s2, clk_prev;
  logic dat_s1, dat_s2;
  logic fall;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      clk_s1   <= 1'b1;
      clk_s2   <= 1'b1;
      clk_prev <= 1'b1;
      dat_s1   <= 1'b1;
      dat_s2   <= 1'b1;
    end else begin
      clk_s1   <= ps2_clk;
      clk_s2   <= clk_s1;
      clk_prev <= clk_s2;
      dat_s1   <= ps2_data;
      dat_s2   <= dat_s1;
    end
  end

  // Edge is a compare of two registered samples; dat_s2 is aligned with clk_s2.
  assign fall = clk_prev & ~clk_s2;

  // ------------------------------------------------------------------
  // Frame FSM
  // ------------------------------------------------------------------
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DATA   = 2'd1,
    S_PARITY = 2'd2,
    S_STOP   = 2'd3
  } state_t;

  state_t          state;
  logic [7:0]      shreg;
  logic [2:0]      bit_cnt;
  logic            par_ok;
  logic [TW-1:0]   to_cnt;
  logic            push_q;
  logic [7:0]      push_byte;
  logic            err_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      shreg     <= '0;
      bit_cnt   <= '0;
      par_ok    <= 1'b0;
      to_cnt    <= '0;
      push_q    <= 1'b0;
      push_byte <= '0;
      err_q     <= 1'b0;
    end else begin
      // push/err are one-cycle pulses into the FIFO/flag stage
      push_q <= 1'b0;
      err_q  <= 1'b0;
      if (fall) begin
        to_cnt <= '0;
        case (state)
          S_IDLE: begin
            if (!dat_s2) begin
              shreg   <= '0;
              bit_cnt <= '0;
              state   <= S_DATA;
            end
          end
          S_DATA: begin
            shreg   <= {dat_s2, shreg[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= S_PARITY;
          end
          S_PARITY: begin
            // odd parity over data + parity bit
            par_ok <= ^{shreg, dat_s2};
            state  <= S_STOP;
          end
          S_STOP: begin
            if (dat_s2 && par_ok) begin
              push_q    <= 1'b1;
              push_byte <= shreg;
            end else begin
              err_q <= 1'b1;
            end
            state <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end else if (state != S_IDLE) begin
        // abandon a stalled frame silently
        if (to_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
          state  <= S_IDLE;
          to_cnt <= '0;
        end else begin
          to_cnt <= to_cnt + 1'b1;
        end
      end
    end
  end

  // ------------------------------------------------------------------
  // Bus decode
  // ------------------------------------------------------------------
  logic hit_status, hit_data;
  assign hit_status = (bus.addr == 32'(ADDR_STATUS));
  assign hit_data   = (bus.addr == 32'(ADDR_DATA));
  assign bus.hit    = hit_status | hit_data;

  // ------------------------------------------------------------------
  // Scan-code FIFO and sticky flags
  // ------------------------------------------------------------------
  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [3:0]    count, count_nxt;
  logic          frame_err, overflow;
  logic          full, empty, pop, do_push, ovf_set, clr;

  assign full    = (count == 4'(FIFO_DEPTH));
  assign empty   = (count == 4'd0);
  assign pop     = bus.wren & hit_data & ~empty;
  // a pop in the same cycle frees the slot the new byte lands in
  assign do_push = push_q & (~full | pop);
  assign ovf_set = push_q & full & ~pop;
  assign clr     = bus.wren & hit_status;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    count_nxt = count;
    if (do_push && !pop)      count_nxt = count + 4'd1;
    else if (pop && !do_push) count_nxt = count - 4'd1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      frame_err <= 1'b0;
      overflow  <= 1'b0;
      key_avail <= 1'b0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_byte;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      count     <= count_nxt;
      key_avail <= (count_nxt != 4'd0);

      // a new error in the clear cycle stays flagged
      if (err_q)    frame_err <= 1'b1;
      else if (clr) frame_err <= 1'b0;
      if (ovf_set)  overflow  <= 1'b1;
      else if (clr) overflow  <= 1'b0;
    end
  end

  // ------------------------------------------------------------------
  // Read data
  // ------------------------------------------------------------------
  always_comb begin
    bus.rdata = '0;
    if (hit_status)
      bus.rdata = {24'b0, full, overflow, frame_err, count, ~empty};
    else if (hit_data && !empty)
      bus.rdata = {24'b0, mem[rd_ptr]};
  end

endmodule

// File: tb/tb_ps2_kbd_mmio.sv
// Self-checking bench for ps2_kbd_mmio: bit-bangs PS/2 frames on the pins and
// checks status/data reads against a scan-code scoreboard and flag model.
module tb_ps2_kbd_mmio;
  localparam int ADDR_STATUS = 4098;
  localparam int ADDR_DATA   = 4099;
  localparam int DEPTH       = 8;
  localparam int TMO         = 50000;

  logic clock    = 1'b0;
  logic reset    = 1'b0;
  logic ps2_clk  = 1'b1;
  logic ps2_data = 1'b1;
  logic key_avail;

  ps2_kbd_mmio_if bus ();

  ps2_kbd_mmio #(
    .FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO),
    .ADDR_STATUS(ADDR_STATUS), .ADDR_DATA(ADDR_DATA)
  ) dut (
    .clock(clock), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .bus(bus), .key_avail(key_avail)
  );

  always #10 clock = ~clock;

  int         n_cmp = 0;
  int         n_err = 0;
  logic [7:0] sb[$];
  logic       m_ferr = 1'b0;
  logic       m_ovf  = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_status();
    int c;
    c = sb.size();
    return {24'b0, (c == DEPTH), m_ovf, m_ferr, 4'(c), (c != 0)};
  endfunction

  task automatic rd(input int a, output logic [31:0] d);
    @(negedge clock);
    bus.addr = 32'(a);
    bus.wren = 1'b0;
    #1 d = bus.rdata;
  endtask

  task automatic wr(input int a);
    @(negedge clock);
    bus.addr = 32'(a);
    bus.wren = 1'b1;
    @(posedge clock);
    #1 bus.wren = 1'b0;
  endtask

  task automatic check_status(input string tag);
    logic [31:0] d;
    rd(ADDR_STATUS, d);
    check(tag, d, model_status());
  endtask

  task automatic pop_check(input string tag);
    logic [31:0] d, e;
    rd(ADDR_DATA, d);
    e = (sb.size() != 0) ? {24'b0, sb.pop_front()} : 32'b0;
    check(tag, d, e);
    wr(ADDR_DATA);
  endtask

  task automatic clear_flags();
    wr(ADDR_STATUS);
    m_ferr = 1'b0;
    m_ovf  = 1'b0;
  endtask

  // mode 0: plain bit; 1: pop lands on the push cycle; 2: check push latency
  task automatic drive_bit(input logic b, input int mode);
    ps2_data = b;
    repeat (4) @(posedge clock);
    #1 ps2_clk = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    if (mode == 1) begin
      bus.addr = 32'(ADDR_DATA);
      bus.wren = 1'b1;
    end
    if (mode == 2) check("lat_3clk_key_avail", {31'b0, key_avail}, 32'd0);
    @(posedge clock);
    #1;
    if (mode == 1) bus.wren = 1'b0;
    if (mode == 2) check("lat_4clk_key_avail", {31'b0, key_avail}, 32'd1);
    repeat (4) @(posedge clock);
    #1 ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic par_flip, input logic stop, input int mode);
    drive_bit(1'b0, 0);
    for (int i = 0; i < 8; i++) drive_bit(b[i], 0);
    drive_bit((~^b) ^ par_flip, 0);
    drive_bit(stop, mode);
    ps2_data = 1'b1;
    repeat (6) @(posedge clock);
    if (!(stop && !par_flip)) m_ferr = 1'b1;
    else if (mode == 1) begin
      void'(sb.pop_front());
      sb.push_back(b);
    end else if (sb.size() < DEPTH) sb.push_back(b);
    else m_ovf = 1'b1;
  endtask

  initial begin
    logic [31:0] d;
    bus.addr = '0;
    bus.wren = 1'b0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b1;

    // reset state and decode
    rd(ADDR_STATUS, d);
    check("rst_status", d, 32'h0);
    check("rst_hit_status", {31'b0, bus.hit}, 32'd1);
    check("rst_key_avail", {31'b0, key_avail}, 32'd0);
    rd(ADDR_DATA, d);
    check("rst_data_empty", d, 32'h0);
    rd(4100, d);
    check("other_rdata", d, 32'h0);
    check("other_hit", {31'b0, bus.hit}, 32'd0);
    wr(ADDR_DATA);
    check_status("pop_empty_ignored");

    // 1: single good frame, latency, pop
    send_frame(8'h1C, 1'b0, 1'b1, 2);
    rd(ADDR_STATUS, d);
    check("t1_status", d, 32'h3);
    check("t1_key_avail", {31'b0, key_avail}, 32'd1);
    wr(4100);
    check_status("t1_other_write");
    pop_check("t1_data");
    rd(ADDR_STATUS, d);
    check("t1_status_after_pop", d, 32'h0);

    // 2: bad parity, bad stop, error clear
    send_frame(8'h1C, 1'b1, 1'b1, 0);
    rd(ADDR_STATUS, d);
    check("t2_parity_err", d, 32'h20);
    clear_flags();
    check_status("t2_cleared");
    send_frame(8'h33, 1'b0, 1'b0, 0);
    check_status("t2_stop_err");
    clear_flags();

    // 3: fill past full, overflow, in-order drain
    for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b0, 1'b1, 0);
    rd(ADDR_STATUS, d);
    check("t3_full_ovf", d, 32'hD1);
    rd(ADDR_DATA, d);
    check("t3_head", d, 32'h01);
    for (int i = 0; i < 8; i++) pop_check($sformatf("t3_pop%0d", i));
    rd(ADDR_STATUS, d);
    check("t3_ovf_only", d, 32'h40);
    clear_flags();

    // 4: pop coinciding with push while full
    for (int i = 0; i < 8; i++) send_frame(8'h11 + 8'(i), 1'b0, 1'b1, 0);
    check_status("t4_full");
    rd(ADDR_DATA, d);
    check("t4_head", d, {24'b0, sb[0]});
    send_frame(8'h19, 1'b0, 1'b1, 1);
    rd(ADDR_STATUS, d);
    check("t4_status", d, 32'h91);
    for (int i = 0; i < 8; i++) pop_check($sformatf("t4_pop%0d", i));
    check_status("t4_empty");

    // 5: stalled partial frame times out silently
    drive_bit(1'b0, 0);
    drive_bit(1'b1, 0);
    drive_bit(1'b0, 0);
    drive_bit(1'b1, 0);
    drive_bit(1'b1, 0);
    drive_bit(1'b0, 0);
    ps2_data = 1'b1;
    repeat (TMO + 20) @(posedge clock);
    send_frame(8'hF0, 1'b0, 1'b1, 0);
    rd(ADDR_STATUS, d);
    check("t5_status", d, 32'h3);
    pop_check("t5_data");

    // 6: reset mid-frame
    send_frame(8'h77, 1'b0, 1'b1, 0);
    drive_bit(1'b0, 0);
    for (int i = 0; i < 4; i++) drive_bit(1'(i & 1), 0);
    @(negedge clock);
    reset = 1'b0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b1;
    sb.delete();
    m_ferr = 1'b0;
    m_ovf  = 1'b0;
    check_status("t6_after_reset");
    send_frame(8'h5A, 1'b0, 1'b1, 0);
    rd(ADDR_STATUS, d);
    check("t6_status", d, 32'h3);
    pop_check("t6_data");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
